// File: rtl/layer1_streamer.sv
// layer1_streamer: reads the 32x32 pooled layer-1 map out of SRAM once the
// pooling engine finishes, streams it over valid/ready and keeps a running
// 32-bit checksum. A 2-entry FIFO hides the SRAM's one-cycle read latency.
module layer1_streamer #(
  parameter int N_WORDS = 1024,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              layer1_ceb,
  output logic              layer1_web,
  output logic [ADDR_W-1:0] layer1_A,
  input  logic [DATA_W-1:0] layer1_Q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [31:0]       checksum,
  output logic              checksum_valid
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic              vld_p1;
  logic              last_p1;
  logic [1:0]        fifo_cnt;
  logic              wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              pop, push, issue, issue_last, start_run;
  logic [2:0]        occ;

  assign start_run  = (state == IDLE) && start;
  assign pop        = out_valid && out_ready;
  assign push       = vld_p1;
  // Occupancy the FIFO will have once the word already in flight lands and
  // this cycle's pop leaves; one more read is allowed only below 2.
  assign occ        = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue      = (state == RUN) && (occ < 3'd2);
  assign issue_last = issue && (rd_cnt == LAST_ADDR);

  assign layer1_ceb     = issue;
  assign layer1_web     = 1'b1;
  assign layer1_A       = issue ? rd_cnt : addr_hold;
  assign out_valid      = (fifo_cnt != 2'd0);
  assign out_data       = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last       = out_valid && fifo_last[rd_ptr];
  assign busy           = (state != IDLE);
  assign checksum_valid = (state == FIN);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && out_last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read issue stage: address counter, held address, in-flight marker (p0 -> p1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt    <= '0;
      addr_hold <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue_last;
      if (start_run) begin
        rd_cnt <= '0;
      end else if (issue) begin
        rd_cnt    <= rd_cnt + 1'b1;
        addr_hold <= rd_cnt;
      end
    end
  end

  // FIFO control: pointers, occupancy and per-entry last tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_cnt  <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_last <= 2'b00;
    end else if (start_run) begin
      fifo_cnt  <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_last <= 2'b00;
    end else begin
      if (push) begin
        fifo_last[wr_ptr] <= last_p1;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO capture stage: SRAM data lands the cycle after the read (p1 -> p2)
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= layer1_Q;
  end

  // Running checksum over accepted words, cleared at the start of each run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= 32'd0;
    end else if (start_run) begin
      checksum <= 32'd0;
    end else if (pop) begin
      checksum <= checksum + {{(32-DATA_W){1'b0}}, out_data};
    end
  end

endmodule

// File: doc/layer1_streamer.md
# layer1_streamer

Read-out stage directly downstream of the atrous-convolution/max-pool engine. Once the engine signals completion, this block reads all 1024 pooled words (32×32, row-major) from the layer-1 SRAM and streams them out over a valid/ready interface. It also computes a 32-bit running checksum of the stream. A 2-entry skid FIFO absorbs the SRAM's 1-cycle read latency, so back-pressure never drops or duplicates a word.

## Interface
- N_WORDS, 1024, words read per run (layer-1 map size)
- ADDR_W, 12, SRAM address width
- DATA_W, 16, word width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  1-cycle pulse (the engine's done); sampled only in IDLE
- layer1_ceb  out  1  SRAM access enable, 1 = access this cycle
- layer1_web  out  1  SRAM write enable, 0 = write; held at 1 (read-only)
- layer1_A  out  ADDR_W  SRAM read address
- layer1_Q  in  DATA_W  SRAM read data, valid the cycle after ceb=1
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts the word this cycle
- out_data  out  DATA_W  streamed word
- out_last  out  1  high with the final (N_WORDS-th) word
- busy  out  1  run in progress
- checksum  out  32  running sum of accepted words
- checksum_valid  out  1  1-cycle pulse: checksum is final

## Operation
- States: IDLE, RUN, DRAIN, FIN.
  - IDLE → RUN on start=1. This clears rd_cnt, the FIFO, and checksum.
  - RUN → DRAIN in the cycle the N_WORDS-th read is issued.
  - DRAIN → FIN on the handshake of the word with out_last.
  - FIN → IDLE unconditionally.
- Read issue (RUN only), combinational:
  - Issue when (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
  - On issue: layer1_ceb=1, layer1_A=rd_cnt; rd_cnt then increments.
  - Otherwise layer1_ceb=0; layer1_A holds its last value.
- inflight is a 1-bit register: set on issue, cleared next cycle. When it is set, layer1_Q is pushed into the FIFO at that clock edge.
- FIFO: 2 entries, registered.
  - out_valid = (count≠0); out_data = head entry.
  - Push and pop in the same cycle are legal; count is unchanged.
  - The issue rule guarantees there is never a push into a full FIFO.
- out_last is a tag stored per FIFO entry. It is set on the entry read from address N_WORDS−1.
- checksum accumulates on every handshake: checksum ← checksum + zero-extended out_data, 32-bit modulo.
- checksum_valid = 1 in FIN only. checksum then holds its value until the next start.
- A start pulse outside IDLE is ignored; it has no effect on the counters or the stream.
- out_ready may toggle arbitrarily. out_data and out_last must stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, rd_cnt=0, inflight=0, fifo count=0, checksum=0.
  - layer1_ceb=0, layer1_web=1, layer1_A=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, checksum_valid=0.
- Reset asserted mid-run aborts immediately to the reset values. No partial stream resumes; the next start restarts from address 0.
- Latency: start in cycle 0 → ceb=1, A=0 in cycle 1 → word0 captured at the end of cycle 2 → out_valid=1 with word0 in cycle 3.
- Throughput with out_ready held at 1: one word per cycle. Word k is valid in cycle 3+k; out_last is in cycle 1026; FIN (checksum_valid) is in cycle 1027.
- busy = 1 in RUN, DRAIN, and FIN (cycles 1..1027 in the no-stall case); 0 in IDLE.
- Stall: with out_ready=0, at most 2 reads complete, then ceb stays 0. Issue resumes in the same cycle out_ready returns to 1.

## Test plan
- SRAM preloaded with word[i]=i, out_ready=1:
  - Words 0..1023 appear in cycles 3..1026; out_last is high only with 0x03FF.
  - checksum=0x0007FE00 with checksum_valid high in cycle 1027; busy falls in cycle 1028.
- out_ready=0 during cycles 10..30:
  - Exactly 2 words are buffered and ceb=0 during the stall.
  - Stream resumes with no gaps, drops, or duplicates; the order matches word[i].
- Random 50% out_ready with word[i]=0xFFFF:
  - All 1024 words are received and checksum=0x03FFFC00.
  - out_data stays stable across every stalled cycle.
- start pulses at cycles 5 and 500 during a run:
  - Both are ignored; the stream and checksum are identical to the no-pulse run.
- rst=0 in cycle 200, released, then a new start:
  - All outputs take their reset values immediately.
  - The new run restarts at address 0 and completes normally.
- Back-to-back runs (second start the cycle after FIN):
  - checksum resets to 0 and the second run reproduces the same 1024-word stream.
